led_matrix_status_scanner: RTL and testbench

//  Time-multiplexed column-scan driver for the irrigation LED matrix. It takes the packed

---
 rtl/led_matrix_status_scanner_if.sv | 24 ++
 rtl/led_matrix_status_scanner.sv | 120 ++++++++++++
 tb/tb_led_matrix_status_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_status_scanner_if.sv
// Status-scanner bus: image/status in from the decoder, column/row drive out to the matrix.
interface led_matrix_status_scanner_if #(
  parameter int N_COLS   = 5,
  parameter int N_ROWS   = 7,
  parameter int STATUS_W = 2
);
  logic                       enable;
  logic [STATUS_W-1:0]        irrigation_status;
  logic [N_COLS*N_ROWS-1:0]   rows_status;
  logic [N_COLS-1:0]          col_sel;
  logic [N_ROWS-1:0]          row_out;
  logic                       frame_done;
  logic                       alert;

  modport master (
    output enable, irrigation_status, rows_status,
    input  col_sel, row_out, frame_done, alert
  );

  modport slave (
    input  enable, irrigation_status, rows_status,
    output col_sel, row_out, frame_done, alert
  );
endinterface

// File: rtl/led_matrix_status_scanner.sv
// Column-scan LED matrix driver with a frame-latched shadow image and a blinking
// alert window that opens whenever the irrigation status code changes.
module led_matrix_status_scanner #(
  parameter int N_COLS       = 5,
  parameter int N_ROWS       = 7,
  parameter int STATUS_W     = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int ALERT_FRAMES = 40,
  parameter int BLINK_FRAMES = 5,
  parameter int ROW_ACT_LOW  = 0,
  parameter int COL_ACT_LOW  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  led_matrix_status_scanner_if.slave   bus
);

  localparam int CW = $clog2(N_COLS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(ALERT_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]     PRE_MAX    = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     COL_MAX    = CW'(N_COLS - 1);
  localparam logic [AW-1:0]     ALERT_INIT = AW'(ALERT_FRAMES);
  localparam logic [BW-1:0]     BLINK_MAX  = BW'(BLINK_FRAMES - 1);
  localparam logic [N_COLS-1:0] COL_OFF    = (COL_ACT_LOW != 0) ? '1 : '0;
  localparam logic [N_ROWS-1:0] ROW_OFF    = (ROW_ACT_LOW != 0) ? '1 : '0;

  logic [PW-1:0]                   presc, presc_nxt;
  logic [CW-1:0]                   col_idx, col_nxt;
  logic [N_COLS-1:0][N_ROWS-1:0]   shadow, shadow_nxt;
  logic [AW-1:0]                   alert_cnt, alert_nxt;
  logic [BW-1:0]                   blink_cnt, blink_nxt;
  logic                            phase, phase_nxt;
  logic [STATUS_W-1:0]             status_q;

  logic                            tick, frame_end, blank;
  logic [N_COLS-1:0]               col_onehot;
  logic [N_ROWS-1:0]               rows_lit;

  logic [N_COLS-1:0]               col_sel_q;
  logic [N_ROWS-1:0]               row_out_q;
  logic                            frame_done_q, alert_q;

  always_comb begin
    presc_nxt  = presc;
    col_nxt    = col_idx;
    shadow_nxt = shadow;
    alert_nxt  = alert_cnt;
    blink_nxt  = blink_cnt;
    phase_nxt  = phase;

    tick      = bus.enable && (presc == PRE_MAX);
    frame_end = tick && (col_idx == COL_MAX);

    if (bus.enable) presc_nxt = tick ? '0 : presc + 1'b1;
    if (tick)       col_nxt   = (col_idx == COL_MAX) ? '0 : col_idx + 1'b1;
    if (frame_end)  shadow_nxt = bus.rows_status;

    // A status change restarts the alert even on a frame-end edge.
    if (status_q != bus.irrigation_status) begin
      alert_nxt = ALERT_INIT;
      blink_nxt = '0;
      phase_nxt = 1'b0;
    end else if (frame_end && (alert_cnt != '0)) begin
      alert_nxt = alert_cnt - 1'b1;
      if (blink_cnt == BLINK_MAX) begin
        blink_nxt = '0;
        phase_nxt = ~phase;
      end else begin
        blink_nxt = blink_cnt + 1'b1;
      end
      if (alert_nxt == '0) begin
        blink_nxt = '0;
        phase_nxt = 1'b0;
      end
    end

    // Drive from post-edge state so column and rows switch together.
    blank      = !bus.enable || ((alert_nxt != '0) && phase_nxt);
    col_onehot = '0;
    if (bus.enable) col_onehot[col_nxt] = 1'b1;
    rows_lit   = blank ? '0 : shadow_nxt[col_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      col_idx      <= '0;
      shadow       <= '0;
      alert_cnt    <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      status_q     <= '0;
      col_sel_q    <= COL_OFF;
      row_out_q    <= ROW_OFF;
      frame_done_q <= 1'b0;
      alert_q      <= 1'b0;
    end else begin
      presc        <= presc_nxt;
      col_idx      <= col_nxt;
      shadow       <= shadow_nxt;
      alert_cnt    <= alert_nxt;
      blink_cnt    <= blink_nxt;
      phase        <= phase_nxt;
      status_q     <= bus.irrigation_status;
      col_sel_q    <= col_onehot ^ COL_OFF;
      row_out_q    <= rows_lit ^ ROW_OFF;
      frame_done_q <= frame_end;
      alert_q      <= (alert_nxt != '0);
    end
  end

  assign bus.col_sel    = col_sel_q;
  assign bus.row_out    = row_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.alert      = alert_q;

endmodule

// File: tb/tb_led_matrix_status_scanner.sv
// Scoreboard bench: expected outputs derive from an enabled-edge count (column =
// edge/SCAN_DIV mod N_COLS, frame ends every SCAN_DIV*N_COLS edges); two polarities.
module tb_led_matrix_status_scanner;
  localparam int NC = 5, NR = 7, SW = 2, SD = 4, AF = 4, BF = 1;
  localparam int FRAME = SD * NC;
  localparam logic [NC*NR-1:0] IMG1 = 35'h1_2345_6789;
  localparam logic [NC*NR-1:0] IMG2 = 35'h7_5A5A_A5A5;

  typedef struct packed {
    logic [NC-1:0] col;
    logic [NR-1:0] row;
    logic          fd;
    logic          al;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [NC*NR-1:0] img = '0;
  logic [SW-1:0] st = '0;

  always #5 clk = ~clk;

  led_matrix_status_scanner_if #(.N_COLS(NC), .N_ROWS(NR), .STATUS_W(SW)) bus_a ();
  led_matrix_status_scanner_if #(.N_COLS(NC), .N_ROWS(NR), .STATUS_W(SW)) bus_b ();

  assign bus_a.enable = en;  assign bus_a.rows_status = img;  assign bus_a.irrigation_status = st;
  assign bus_b.enable = en;  assign bus_b.rows_status = img;  assign bus_b.irrigation_status = st;

  led_matrix_status_scanner #(.N_COLS(NC), .N_ROWS(NR), .STATUS_W(SW), .SCAN_DIV(SD),
    .ALERT_FRAMES(AF), .BLINK_FRAMES(BF), .ROW_ACT_LOW(0), .COL_ACT_LOW(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  led_matrix_status_scanner #(.N_COLS(NC), .N_ROWS(NR), .STATUS_W(SW), .SCAN_DIV(SD),
    .ALERT_FRAMES(AF), .BLINK_FRAMES(BF), .ROW_ACT_LOW(1), .COL_ACT_LOW(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  exp_t got_a, got_b;
  assign got_a = {bus_a.col_sel, bus_a.row_out, bus_a.frame_done, bus_a.alert};
  assign got_b = {bus_b.col_sel, bus_b.row_out, bus_b.frame_done, bus_b.alert};

  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;

  // reference state: enabled edges since reset, latched image, last status change
  int kscan, kchg;
  bit chg_seen;
  logic [NC*NR-1:0] shadow_ref;
  logic [SW-1:0] st_prev;

  function automatic exp_t inv(input exp_t x);
    exp_t y = x;
    y.col = ~x.col;
    y.row = ~x.row;
    return y;
  endfunction

  task automatic ref_init();
    kscan = 0; kchg = 0; chg_seen = 0; shadow_ref = '0; st_prev = '0;
  endtask

  // Drive one clock of stimulus, push its expected outputs, advance past the edge.
  task automatic step(input logic e, input logic [NC*NR-1:0] r, input logic [SW-1:0] s);
    exp_t x;
    int c, f;
    bit al, blank;
    en = e; img = r; st = s;
    x.fd = 1'b0;
    if (e) begin
      kscan++;
      if (kscan % FRAME == 0) begin x.fd = 1'b1; shadow_ref = r; end
    end
    if (s != st_prev) begin chg_seen = 1; kchg = kscan; end
    st_prev = s;
    f = kscan / FRAME - kchg / FRAME;
    al = chg_seen && (f < AF);
    blank = !e || (al && ((f / BF) % 2 == 1));
    c = (kscan / SD) % NC;
    x.col = e ? NC'(1 << c) : '0;
    x.row = blank ? '0 : shadow_ref[c*NR +: NR];
    x.al = al;
    sbq.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t x;
    reset = 1'b1; en = 1'b0; img = IMG1; st = '0;
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back('0);
    x = sbq.pop_front(); n_tests += 2;
    if (got_a !== x) begin n_fail++; $display("FAIL reset normal got %h exp %h", got_a, x); end
    if (got_b !== inv(x)) begin n_fail++; $display("FAIL reset inverted got %h exp %h", got_b, inv(x)); end
    @(negedge clk); reset = 1'b0;
    ref_init();
  endtask

  task automatic test_scan();
    exp_t x;
    for (int i = 0; i < 45; i++) begin
      step(1'b1, IMG1, 2'd0);
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL scan[%0d] normal got %h exp %h", i, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL scan[%0d] inverted got %h exp %h", i, got_b, inv(x)); end
    end
  endtask

  task automatic test_frame_buffer();
    exp_t x;
    bit chg = 0;
    for (int i = 0; i < 40; i++) begin
      if ((kscan / SD) % NC == 2) chg = 1;
      step(1'b1, chg ? IMG2 : IMG1, 2'd0);
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL framebuf[%0d] normal got %h exp %h", i, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL framebuf[%0d] inverted got %h exp %h", i, got_b, inv(x)); end
    end
  endtask

  task automatic test_alert_blink();
    exp_t x;
    for (int i = 0; i < 110; i++) begin
      step(1'b1, IMG2, (i >= 3) ? 2'd2 : 2'd0);
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL alert[%0d] normal got %h exp %h", i, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL alert[%0d] inverted got %h exp %h", i, got_b, inv(x)); end
    end
  endtask

  task automatic test_alert_on_frame_end();
    exp_t x;
    bit chg = 0;
    for (int i = 0; i < 120; i++) begin
      if ((kscan + 1) % FRAME == 0) chg = 1;
      step(1'b1, IMG1, chg ? 2'd1 : 2'd2);
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL alert_fe[%0d] normal got %h exp %h", i, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL alert_fe[%0d] inverted got %h exp %h", i, got_b, inv(x)); end
    end
  endtask

  task automatic test_enable_pause();
    exp_t x;
    bit begun = 0;
    int off = 0;
    logic e;
    for (int i = 0; i < 90; i++) begin
      if (kscan % SD == 2) begun = 1;
      e = !(begun && off < 10);
      step(e, IMG2, (begun && off >= 3) ? 2'd3 : 2'd1);
      if (begun) off++;
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL pause[%0d] normal got %h exp %h", i, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL pause[%0d] inverted got %h exp %h", i, got_b, inv(x)); end
    end
  endtask

  task automatic test_reset_midscan();
    exp_t x;
    int guard = 0;
    while ((kscan / SD) % NC != 3 && guard < 2 * FRAME) begin
      step(1'b1, IMG1, 2'd3);
      guard++;
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL midscan_pre[%0d] normal got %h exp %h", guard, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL midscan_pre[%0d] inverted got %h exp %h", guard, got_b, inv(x)); end
    end
    #2 reset = 1'b1;
    #1;
    sbq.push_back('0);
    x = sbq.pop_front(); n_tests += 2;
    if (got_a !== x) begin n_fail++; $display("FAIL midscan_async normal got %h exp %h", got_a, x); end
    if (got_b !== inv(x)) begin n_fail++; $display("FAIL midscan_async inverted got %h exp %h", got_b, inv(x)); end
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    ref_init();
    for (int i = 0; i < 25; i++) begin
      step(1'b1, IMG1, 2'd3);
      x = sbq.pop_front(); n_tests += 2;
      if (got_a !== x) begin n_fail++; $display("FAIL midscan_post[%0d] normal got %h exp %h", i, got_a, x); end
      if (got_b !== inv(x)) begin n_fail++; $display("FAIL midscan_post[%0d] inverted got %h exp %h", i, got_b, inv(x)); end
    end
  endtask

  initial begin
    ref_init();
    test_reset();
    test_scan();
    test_frame_buffer();
    test_alert_blink();
    test_alert_on_frame_end();
    test_enable_pause();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
